sobel_frame_sequencer: RTL and testbench

Frame-level controller for the Sobel engine. It accepts a pixel stream and writes one full frame into BRAM0 through port 0. It then kicks the Sobel/move engine with a single-cycle enable, using the captured mode and frame size, and waits for the engine's done pulse. Finally it hands BRAM1 to a downstream reader under a ready/ack handshake. A watchdog flags an engine that never completes.

---
 rtl/sobel_frame_sequencer.sv | 127 ++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_sequencer.sv
// Frame-level controller for the Sobel engine: loads one frame into BRAM0, kicks
// the engine, waits for done under a watchdog, then releases BRAM1 to a reader.
module sobel_frame_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 5,
  parameter int IMAGE_HEIGHT = 5,
  parameter int TIMEOUT      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_mode_sobel,
  input  logic                  i_pix_valid,
  input  logic [DATA_WIDTH-1:0] i_pix_data,
  output logic                  o_pix_ready,
  output logic                  o_b0_ce,
  output logic                  o_b0_we,
  output logic [ADDR_WIDTH-1:0] o_b0_addr,
  output logic [DATA_WIDTH-1:0] o_b0_d,
  output logic                  o_eng_en,
  output logic                  o_eng_run,
  output logic [ADDR_WIDTH-1:0] o_eng_num_cnt,
  input  logic                  i_eng_idle,
  input  logic                  i_eng_done,
  output logic                  o_frame_ready,
  input  logic                  i_frame_ack,
  input  logic                  i_clr_err,
  output logic                  o_busy,
  output logic                  o_timeout_err,
  output logic [15:0]           o_frame_cnt
);

  localparam int unsigned N    = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_WIDTH-1:0] NUM_CNT = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] N_LAST  = ADDR_WIDTH'(N - 1);
  localparam logic [WD_W-1:0]       WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_RUN,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      pix_cnt_q   <= '0;
      wdog_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pix_cnt_q   <= pix_cnt_d;
      wdog_q      <= wdog_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pix_cnt_d   = pix_cnt_q;
    wdog_d      = wdog_q;
    frame_cnt_d = frame_cnt_q;
    accept      = (state_q == S_LOAD) && i_pix_valid;
    unique case (state_q)
      S_IDLE: begin
        if (i_start && i_eng_idle) begin
          state_d   = S_LOAD;
          mode_d    = i_mode_sobel;
          pix_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          pix_cnt_d = pix_cnt_q + ADDR_WIDTH'(1);
          if (pix_cnt_q == N_LAST) state_d = S_KICK;
        end
      end
      S_KICK: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // done takes priority over a simultaneous watchdog expiry
        if (i_eng_done) begin
          state_d     = S_DRAIN;
          frame_cnt_d = frame_cnt_q + 16'(1);
        end else if (wdog_q == WD_LAST) begin
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_DRAIN: if (i_frame_ack) state_d = S_IDLE;
      S_ERR:   if (i_clr_err)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_pix_ready   = (state_q == S_LOAD);
  assign o_b0_ce       = accept;
  assign o_b0_we       = accept;
  assign o_b0_addr     = accept ? pix_cnt_q  : '0;
  assign o_b0_d        = accept ? i_pix_data : '0;
  assign o_eng_en      = (state_q == S_KICK);
  assign o_eng_run     = mode_q && ((state_q == S_KICK) || (state_q == S_RUN) || (state_q == S_DRAIN));
  assign o_eng_num_cnt = NUM_CNT;
  assign o_frame_ready = (state_q == S_DRAIN);
  assign o_busy        = (state_q != S_IDLE);
  assign o_timeout_err = (state_q == S_ERR);
  assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Scoreboard bench for sobel_frame_sequencer: stimulus pushes expected BRAM writes,
// engine kicks and frame releases; a negedge monitor pops and compares them.
module tb_sobel_frame_sequencer;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int N  = 25;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 0, i_mode_sobel = 0, i_pix_valid = 0;
  logic [DW-1:0] i_pix_data = '0;
  logic i_eng_idle = 1, i_eng_done = 0, i_frame_ack = 0, i_clr_err = 0;
  logic o_pix_ready, o_b0_ce, o_b0_we, o_eng_en, o_eng_run, o_frame_ready, o_busy, o_timeout_err;
  logic [AW-1:0] o_b0_addr, o_eng_num_cnt;
  logic [DW-1:0] o_b0_d;
  logic [15:0]   o_frame_cnt;

  sobel_frame_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode_sobel(i_mode_sobel),
    .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
    .o_b0_ce(o_b0_ce), .o_b0_we(o_b0_we), .o_b0_addr(o_b0_addr), .o_b0_d(o_b0_d),
    .o_eng_en(o_eng_en), .o_eng_run(o_eng_run), .o_eng_num_cnt(o_eng_num_cnt),
    .i_eng_idle(i_eng_idle), .i_eng_done(i_eng_done), .o_frame_ready(o_frame_ready),
    .i_frame_ack(i_frame_ack), .i_clr_err(i_clr_err), .o_busy(o_busy),
    .o_timeout_err(o_timeout_err), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [15:0] cnt; logic mode; } fr_t;
  wr_t  wq[$];
  logic eq[$];
  fr_t  fq[$];

  int checks = 0;
  int failures = 0;
  int frames_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every BRAM write, kick and frame release must match the next queued expectation
  logic prev_en = 0, prev_rdy = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_b0_we === 1'b1) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual_addr=%0h required=none", o_b0_addr);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("b0_addr", o_b0_addr, w.addr);
          chk("b0_data", o_b0_d, w.data);
          chk("b0_ce", o_b0_ce, 1);
        end
      end
      if (o_eng_en === 1'b1) begin
        chk("eng_en_single_cycle", prev_en, 0);
        if (!prev_en) begin
          if (eq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_kick actual=1 required=0");
          end else begin
            chk("eng_run_at_kick", o_eng_run, eq.pop_front());
            chk("eng_num_cnt", o_eng_num_cnt, N);
          end
        end
      end
      if (o_frame_ready === 1'b1 && !prev_rdy) begin
        if (fq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame_ready actual=1 required=0");
        end else begin
          fr_t f;
          f = fq.pop_front();
          chk("frame_cnt_at_release", o_frame_cnt, f.cnt);
          chk("eng_run_at_release", o_eng_run, f.mode);
        end
      end
    end
    prev_en  = (o_eng_en === 1'b1);
    prev_rdy = (o_frame_ready === 1'b1);
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, o_pix_ready, 0);
    chk({tag, "_b0_ce"}, o_b0_ce, 0);
    chk({tag, "_b0_we"}, o_b0_we, 0);
    chk({tag, "_b0_addr"}, o_b0_addr, 0);
    chk({tag, "_b0_d"}, o_b0_d, 0);
    chk({tag, "_eng_en"}, o_eng_en, 0);
    chk({tag, "_eng_run"}, o_eng_run, 0);
    chk({tag, "_frame_ready"}, o_frame_ready, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_timeout_err"}, o_timeout_err, 0);
    chk({tag, "_frame_cnt"}, o_frame_cnt, frames_model);
    chk({tag, "_num_cnt"}, o_eng_num_cnt, N);
  endtask

  // stall: 0 = back-to-back ramp 0x10.., 1 = alternating valid, 2 = random gaps.
  // npix < N aborts the load with a reset after npix pixels.
  task automatic load_frame(input logic mode, input int stall, input int npix);
    logic [DW-1:0] d;
    i_start = 1; i_mode_sobel = mode;
    eq.push_back(mode);
    step();
    i_start = 0; i_mode_sobel = $urandom_range(0, 1);
    chk("pix_ready_after_start", o_pix_ready, 1);
    chk("busy_after_start", o_busy, 1);
    for (int k = 0; k < npix; k++) begin
      if (stall == 2) begin
        repeat ($urandom_range(0, 2)) begin
          i_pix_valid = 0; i_pix_data = DW'($urandom); step();
        end
      end
      d = (stall == 0) ? DW'(8'h10 + k) : DW'($urandom);
      wq.push_back('{addr: AW'(k), data: d});
      i_pix_valid = 1; i_pix_data = d;
      step();
      if (stall == 1 && k < npix - 1) begin
        i_pix_valid = 0; i_pix_data = DW'($urandom); step();
      end
    end
    i_pix_valid = 0;
    if (npix < N) begin
      rst = 1;
      void'(eq.pop_back());
      step(); step();
      rst = 0;
      frames_model = 0;
      check_reset_outputs("midload_reset");
    end else begin
      chk("eng_en_after_last_pixel", o_eng_en, 1);
      chk("pix_ready_in_kick", o_pix_ready, 0);
      step();
      chk("eng_en_dropped", o_eng_en, 0);
      chk("busy_in_run", o_busy, 1);
    end
  endtask

  task automatic finish_frame(input logic mode, input int dly, input int ack_dly, input bit start_in_drain);
    repeat (dly) step();
    i_eng_done = 1;
    fq.push_back('{cnt: 16'(frames_model + 1), mode: mode});
    step();
    i_eng_done = 0;
    frames_model++;
    chk("frame_ready_after_done", o_frame_ready, 1);
    chk("frame_cnt_after_done", o_frame_cnt, frames_model);
    chk("no_err_after_done", o_timeout_err, 0);
    for (int a = 0; a < ack_dly; a++) begin
      i_start = start_in_drain && (a == 0);
      step();
      i_start = 0;
      chk("frame_ready_held", o_frame_ready, 1);
      chk("eng_run_held", o_eng_run, mode);
    end
    i_frame_ack = 1;
    step();
    i_frame_ack = 0;
    chk("frame_ready_after_ack", o_frame_ready, 0);
    chk("idle_after_ack", o_busy, 0);
    chk("eng_run_idle", o_eng_run, 0);
    step();
    chk("start_not_queued", o_busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    step(); step();
    check_reset_outputs("reset");
    rst = 0;
    step();
    check_reset_outputs("post_reset");

    // move frame, back-to-back ramp, done after 40 cycles
    load_frame(1'b0, 0, N);
    finish_frame(1'b0, 40, 0, 0);

    // sobel frame with alternating valid, start attempt during DRAIN
    load_frame(1'b1, 1, N);
    finish_frame(1'b1, 7, 3, 1);

    // start while engine busy is ignored
    i_eng_idle = 0; i_start = 1;
    repeat (4) begin step(); chk("start_blocked_by_engine", o_busy, 0); end
    i_start = 0; i_eng_idle = 1;

    // watchdog expiry
    load_frame(1'b0, 0, N);
    repeat (TO - 1) step();
    chk("no_err_before_expiry", o_timeout_err, 0);
    chk("busy_before_expiry", o_busy, 1);
    step();
    chk("err_at_expiry", o_timeout_err, 1);
    chk("frame_cnt_unchanged_on_err", o_frame_cnt, frames_model);
    i_eng_done = 1; i_frame_ack = 1;
    step();
    i_eng_done = 0; i_frame_ack = 0;
    chk("err_sticky_vs_done_ack", o_timeout_err, 1);
    chk("frame_ready_not_in_err", o_frame_ready, 0);
    repeat (3) step();
    chk("err_sticky", o_timeout_err, 1);
    i_clr_err = 1;
    step();
    i_clr_err = 0;
    chk("err_cleared", o_timeout_err, 0);
    chk("idle_after_clr", o_busy, 0);

    // normal frame after error, then done coinciding with expiry
    load_frame(1'b1, 2, N);
    finish_frame(1'b1, 5, 1, 0);
    load_frame(1'b0, 0, N);
    finish_frame(1'b0, TO - 1, 0, 0);

    // ack already high at DRAIN entry: a single release
    load_frame(1'b1, 0, N);
    i_frame_ack = 1;
    repeat (3) step();
    i_eng_done = 1;
    fq.push_back('{cnt: 16'(frames_model + 1), mode: 1'b1});
    step();
    i_eng_done = 0;
    frames_model++;
    chk("held_ack_frame_ready", o_frame_ready, 1);
    step();
    chk("held_ack_release", o_frame_ready, 0);
    chk("held_ack_idle", o_busy, 0);
    repeat (3) step();
    chk("held_ack_single", o_frame_ready, 0);
    chk("held_ack_cnt", o_frame_cnt, frames_model);
    i_frame_ack = 0;

    // reset in the middle of a load, then a full frame from address 0
    load_frame(1'b0, 0, 11);
    wq.delete();
    load_frame(1'b0, 2, N);
    finish_frame(1'b0, $urandom_range(0, 30), 1, 0);
    chk("frame_cnt_after_midload_reset", o_frame_cnt, 1);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      load_frame(m, 2, N);
      finish_frame(m, $urandom_range(0, TO - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    step(); step();
    chk("write_queue_drained", wq.size(), 0);
    chk("kick_queue_drained", eq.size(), 0);
    chk("release_queue_drained", fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
